// File: rtl/lib_pipe_align.sv
// Deskews per-stage taps of an FF_STEP-registered stage chain so every stage of a token
// leaves on the same cycle, qualified by one valid, with mismatch flag and saturating count.
module lib_pipe_align #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned STAGE_NUM = 8,
  parameter int unsigned FF_STEP   = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i     [STAGE_NUM-1:0],
  input  logic             vld_i      [STAGE_NUM-1:0],
  input  logic             clr_i,
  output logic [WIDTH-1:0] data_o     [STAGE_NUM-1:0],
  output logic             vld_o,
  output logic             mismatch_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  if (FF_STEP < 1 || FF_STEP > STAGE_NUM || STAGE_NUM < 2) begin : g_bad_param
    $fatal(1, "lib_pipe_align: FF_STEP must be 1..STAGE_NUM and STAGE_NUM >= 2");
  end

  // Guarded divisor keeps elaboration arithmetic defined even for an illegal FF_STEP.
  localparam int unsigned STEP = (FF_STEP == 0) ? 1 : FF_STEP;
  localparam int unsigned LMAX = (STAGE_NUM - 1) / STEP;

  logic [WIDTH-1:0]     dly_data [STAGE_NUM-1:0];
  logic [STAGE_NUM-1:0] dly_vld;

  for (genvar k = 0; k < STAGE_NUM; k++) begin : g_tap
    localparam int unsigned D = LMAX - (k / STEP);

    if (D == 0) begin : g_pass
      assign dly_data[k] = data_i[k];
      assign dly_vld[k]  = vld_i[k];
    end else begin : g_dly
      logic [WIDTH-1:0] dsr [D];
      logic [D-1:0]     vsr;

      // Data lines carry no reset: payload is only meaningful under vld_o.
      always_ff @(posedge clk) begin
        dsr[0] <= data_i[k];
        for (int unsigned i = 1; i < D; i++) begin
          dsr[i] <= dsr[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst || clr_i) begin
          vsr <= '0;
        end else begin
          vsr[0] <= vld_i[k];
          for (int unsigned i = 1; i < D; i++) begin
            vsr[i] <= vsr[i-1];
          end
        end
      end

      assign dly_data[k] = dsr[D-1];
      assign dly_vld[k]  = vsr[D-1];
    end
  end

  always_ff @(posedge clk) begin
    data_o <= dly_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      vld_o      <= 1'b0;
      mismatch_o <= 1'b0;
      err_cnt_o  <= '0;
    end else begin
      vld_o      <= &dly_vld;
      mismatch_o <= (|dly_vld) & ~(&dly_vld);
      if (mismatch_o && (err_cnt_o != '1)) begin
        err_cnt_o <= err_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lib_pipe_align.sv
// Directed bench for lib_pipe_align: S=8/F=4 instances with 8-bit and 2-bit counters
// share stimulus; an S=4/F=1 instance covers the fully-registered chain.
module tb_lib_pipe_align;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [7:0] data [7:0];
  logic       vld  [7:0];

  logic [7:0] a_data [7:0];
  logic       a_vld, a_mis;
  logic [7:0] a_cnt;
  logic [7:0] b_data [7:0];
  logic       b_vld, b_mis;
  logic [1:0] b_cnt;

  logic [7:0] c_in   [3:0];
  logic       c_vin  [3:0];
  logic [7:0] c_data [3:0];
  logic       c_vld, c_mis;
  logic [7:0] c_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lib_pipe_align #(.WIDTH(8), .STAGE_NUM(8), .FF_STEP(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .data_i(data), .vld_i(vld), .clr_i(clr),
    .data_o(a_data), .vld_o(a_vld), .mismatch_o(a_mis), .err_cnt_o(a_cnt));

  lib_pipe_align #(.WIDTH(8), .STAGE_NUM(8), .FF_STEP(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .data_i(data), .vld_i(vld), .clr_i(clr),
    .data_o(b_data), .vld_o(b_vld), .mismatch_o(b_mis), .err_cnt_o(b_cnt));

  lib_pipe_align #(.WIDTH(8), .STAGE_NUM(4), .FF_STEP(1), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst), .data_i(c_in), .vld_i(c_vin), .clr_i(clr),
    .data_o(c_data), .vld_o(c_vld), .mismatch_o(c_mis), .err_cnt_o(c_cnt));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Stages 0-3 carry token "lo", stages 4-7 carry token "hi" (one cycle older).
  task automatic drive(input logic [7:0] lo_base, input logic [3:0] lo_v,
                       input logic [7:0] hi_base, input logic [3:0] hi_v);
    for (int k = 0; k < 4; k++) begin
      data[k]   = lo_base + 8'(k);
      vld[k]    = lo_v[k];
      data[k+4] = hi_base + 8'(k + 4);
      vld[k+4]  = hi_v[k];
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(8'h00, 4'h0, 8'h00, 4'h0);
    step;
    step;
    rst = 1'b0;
    checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL reset_a_vld: got %0b want 0", a_vld); end
    checks++; if (a_mis !== 1'b0) begin errors++; $display("FAIL reset_a_mis: got %0b want 0", a_mis); end
    checks++; if (a_cnt !== 8'd0) begin errors++; $display("FAIL reset_a_cnt: got %0d want 0", a_cnt); end
    checks++; if (b_cnt !== 2'd0) begin errors++; $display("FAIL reset_b_cnt: got %0d want 0", b_cnt); end
    checks++; if (c_vld !== 1'b0 || c_mis !== 1'b0) begin errors++; $display("FAIL reset_c: got vld=%0b mis=%0b want 0 0", c_vld, c_mis); end
  endtask

  task automatic test_single;
    drive(8'h10, 4'hF, 8'h00, 4'h0);
    step;
    drive(8'h00, 4'h0, 8'h10, 4'hF);
    step;
    checks++; if (a_vld !== 1'b1) begin errors++; $display("FAIL single_vld: got %0b want 1", a_vld); end
    checks++; if (a_mis !== 1'b0) begin errors++; $display("FAIL single_mis: got %0b want 0", a_mis); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (a_data[k] !== 8'(8'h10 + k)) begin
        errors++; $display("FAIL single_data[%0d]: got %02h want %02h", k, a_data[k], 8'(8'h10 + k));
      end
    end
    drive(8'h00, 4'h0, 8'h00, 4'h0);
    step;
    checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL single_vld_after: got %0b want 0", a_vld); end
  endtask

  task automatic test_back_to_back;
    for (int c = 0; c < 5; c++) begin
      drive(8'(c * 16), (c < 4) ? 4'hF : 4'h0, 8'((c - 1) * 16), (c >= 1) ? 4'hF : 4'h0);
      step;
      if (c >= 1) begin
        checks++; if (a_vld !== 1'b1) begin errors++; $display("FAIL b2b_vld id%0d: got %0b want 1", c - 1, a_vld); end
        for (int k = 0; k < 8; k++) begin
          checks++;
          if (a_data[k] !== 8'((c - 1) * 16 + k)) begin
            errors++; $display("FAIL b2b_data id%0d[%0d]: got %02h want %02h", c - 1, k, a_data[k], 8'((c - 1) * 16 + k));
          end
        end
      end
    end
    drive(8'h00, 4'h0, 8'h00, 4'h0);
    step;
    checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL b2b_vld_end: got %0b want 0", a_vld); end
  endtask

  task automatic test_mismatch;
    drive(8'h10, 4'hF, 8'h00, 4'h0);
    step;
    drive(8'h00, 4'h0, 8'h10, 4'b1101);
    step;
    checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL mis_vld: got %0b want 0", a_vld); end
    checks++; if (a_mis !== 1'b1) begin errors++; $display("FAIL mis_flag: got %0b want 1", a_mis); end
    checks++; if (a_cnt !== 8'd0) begin errors++; $display("FAIL mis_cnt_pre: got %0d want 0", a_cnt); end
    drive(8'h00, 4'h0, 8'h00, 4'h0);
    step;
    checks++; if (a_cnt !== 8'd1) begin errors++; $display("FAIL mis_cnt: got %0d want 1", a_cnt); end
    checks++; if (a_mis !== 1'b0) begin errors++; $display("FAIL mis_flag_after: got %0b want 0", a_mis); end
  endtask

  task automatic test_saturation;
    clr = 1'b1;
    step;
    clr = 1'b0;
    checks++; if (a_cnt !== 8'd0 || b_cnt !== 2'd0) begin errors++; $display("FAIL sat_pre_clr: got a=%0d b=%0d want 0 0", a_cnt, b_cnt); end
    for (int c = 0; c < 7; c++) begin
      drive(8'(c * 16), (c < 5) ? 4'hF : 4'h0, 8'((c - 1) * 16), (c >= 1 && c < 6) ? 4'b1101 : 4'h0);
      step;
      if (c >= 2) begin
        checks++;
        if (b_cnt !== 2'((c - 1 > 3) ? 3 : c - 1)) begin
          errors++; $display("FAIL sat_b_cnt step%0d: got %0d want %0d", c, b_cnt, (c - 1 > 3) ? 3 : c - 1);
        end
        checks++;
        if (a_cnt !== 8'(c - 1)) begin
          errors++; $display("FAIL sat_a_cnt step%0d: got %0d want %0d", c, a_cnt, c - 1);
        end
      end
    end
    drive(8'h00, 4'h0, 8'h00, 4'h0);
    clr = 1'b1;
    step;
    clr = 1'b0;
    checks++; if (b_cnt !== 2'd0) begin errors++; $display("FAIL sat_clr_b: got %0d want 0", b_cnt); end
    checks++; if (a_cnt !== 8'd0) begin errors++; $display("FAIL sat_clr_a: got %0d want 0", a_cnt); end
  endtask

  task automatic test_reset_midstream;
    drive(8'h30, 4'hF, 8'h00, 4'h0);
    step;
    drive(8'h00, 4'h0, 8'h30, 4'b1101);
    step;
    drive(8'h00, 4'h0, 8'h00, 4'h0);
    step;
    checks++; if (a_cnt !== 8'd1) begin errors++; $display("FAIL rstm_cnt_pre: got %0d want 1", a_cnt); end
    drive(8'h40, 4'hF, 8'h00, 4'h0);
    step;
    drive(8'h00, 4'h0, 8'h40, 4'hF);
    rst = 1'b1;
    step;
    rst = 1'b0;
    checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL rstm_vld: got %0b want 0", a_vld); end
    checks++; if (a_mis !== 1'b0) begin errors++; $display("FAIL rstm_mis: got %0b want 0", a_mis); end
    checks++; if (a_cnt !== 8'd0) begin errors++; $display("FAIL rstm_cnt: got %0d want 0", a_cnt); end
    drive(8'h50, 4'hF, 8'h00, 4'h0);
    step;
    checks++; if (a_vld !== 1'b0 || a_mis !== 1'b0) begin errors++; $display("FAIL rstm_rel1: got vld=%0b mis=%0b want 0 0", a_vld, a_mis); end
    drive(8'h00, 4'h0, 8'h50, 4'hF);
    step;
    checks++; if (a_vld !== 1'b1) begin errors++; $display("FAIL rstm_rel2_vld: got %0b want 1", a_vld); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (a_data[k] !== 8'(8'h50 + k)) begin
        errors++; $display("FAIL rstm_data[%0d]: got %02h want %02h", k, a_data[k], 8'(8'h50 + k));
      end
    end
    drive(8'h00, 4'h0, 8'h00, 4'h0);
    step;
  endtask

  task automatic test_step1;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) begin
        c_in[k]  = 8'hA0 + 8'(k);
        c_vin[k] = (k == c);
      end
      step;
      if (c < 3) begin
        checks++; if (c_vld !== 1'b0) begin errors++; $display("FAIL s1_early_vld step%0d: got %0b want 0", c, c_vld); end
      end
    end
    for (int k = 0; k < 4; k++) c_vin[k] = 1'b0;
    checks++; if (c_vld !== 1'b1) begin errors++; $display("FAIL s1_vld: got %0b want 1", c_vld); end
    checks++; if (c_mis !== 1'b0) begin errors++; $display("FAIL s1_mis: got %0b want 0", c_mis); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (c_data[k] !== 8'(8'hA0 + k)) begin
        errors++; $display("FAIL s1_data[%0d]: got %02h want %02h", k, c_data[k], 8'(8'hA0 + k));
      end
    end
    step;
    checks++; if (c_vld !== 1'b0) begin errors++; $display("FAIL s1_vld_after: got %0b want 0", c_vld); end
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    drive(8'h00, 4'h0, 8'h00, 4'h0);
    for (int k = 0; k < 4; k++) begin
      c_in[k]  = 8'h00;
      c_vin[k] = 1'b0;
    end
    test_reset;
    test_single;
    test_back_to_back;
    test_mismatch;
    test_saturation;
    test_reset_midstream;
    test_step1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
